// File: rtl/fpdiv_ctrl.sv
// fpdiv_ctrl: Moore sequencer for the fpdiv Goldschmidt divider datapath.
// One start/done handshake runs seed, ITER refinement pairs, then a one-cycle DONE.
module fpdiv_ctrl #(
  parameter int unsigned ITER = 3
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [2:0] iter_o,
  output logic       sel_muxa_o,
  output logic [1:0] sel_muxb_o,
  output logic       loada_o,
  output logic       loadb_o,
  output logic       loadc_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEED_D = 3'd1,
    S_SEED_N = 3'd2,
    S_ITER_D = 3'd3,
    S_ITER_N = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [2:0] LastIter = 3'(ITER - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic       busy_q, done_q, muxa_q, loada_q, loadb_q, loadc_q;
  logic [2:0] iter_q;
  logic [1:0] muxb_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_SEED_D;
      S_SEED_D: state_d = S_SEED_N;
      S_SEED_N: begin
        state_d = S_ITER_D;
        cnt_d   = 3'd0;
      end
      S_ITER_D: state_d = S_ITER_N;
      S_ITER_N: begin
        if (cnt_q == LastIter) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ITER_D;
          cnt_d   = cnt_q + 3'd1;
        end
      end
      S_DONE:   state_d = start_i ? S_SEED_D : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet still
  // line up with the state they describe.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      iter_q  <= 3'd0;
      muxa_q  <= 1'b0;
      muxb_q  <= 2'b00;
      loada_q <= 1'b0;
      loadb_q <= 1'b0;
      loadc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      iter_q  <= 3'd0;
      muxa_q  <= 1'b0;
      muxb_q  <= 2'b00;
      loada_q <= 1'b0;
      loadb_q <= 1'b0;
      loadc_q <= 1'b0;
      case (state_d)
        S_SEED_D: begin
          busy_q  <= 1'b1;
          loadb_q <= 1'b1;
        end
        S_SEED_N: begin
          busy_q  <= 1'b1;
          loada_q <= 1'b1;
          loadc_q <= 1'b1;
        end
        S_ITER_D: begin
          busy_q  <= 1'b1;
          iter_q  <= cnt_d;
          muxa_q  <= 1'b1;
          muxb_q  <= 2'b01;
          loadb_q <= 1'b1;
        end
        S_ITER_N: begin
          busy_q  <= 1'b1;
          iter_q  <= cnt_d;
          muxa_q  <= 1'b1;
          muxb_q  <= 2'b01;
          loada_q <= 1'b1;
          loadc_q <= 1'b1;
        end
        S_DONE:  done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign iter_o     = iter_q;
  assign sel_muxa_o = muxa_q;
  assign sel_muxb_o = muxb_q;
  assign loada_o    = loada_q;
  assign loadb_o    = loadb_q;
  assign loadc_o    = loadc_q;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// tb_fpdiv_ctrl: scoreboard bench for fpdiv_ctrl (ITER=3 and ITER=1 instances)
// with a small real-valued Goldschmidt datapath driven by the control word.
module tb_fpdiv_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ITER=3 instance
  logic       rst3_n = 1'b0, start3 = 1'b0;
  logic       busy3, done3, muxa3, la3, lb3, lc3;
  logic [2:0] iter3;
  logic [1:0] muxb3;
  logic [10:0] w3;
  assign w3 = {busy3, done3, iter3, muxa3, muxb3, la3, lb3, lc3};

  fpdiv_ctrl #(.ITER(3)) u3 (
    .clk_i(clk), .reset_ni(rst3_n), .start_i(start3),
    .busy_o(busy3), .done_o(done3), .iter_o(iter3),
    .sel_muxa_o(muxa3), .sel_muxb_o(muxb3),
    .loada_o(la3), .loadb_o(lb3), .loadc_o(lc3)
  );

  // ITER=1 instance
  logic       rst1_n = 1'b0, start1 = 1'b0;
  logic       busy1, done1, muxa1, la1, lb1, lc1;
  logic [2:0] iter1;
  logic [1:0] muxb1;
  logic [10:0] w1;
  assign w1 = {busy1, done1, iter1, muxa1, muxb1, la1, lb1, lc1};

  fpdiv_ctrl #(.ITER(1)) u1 (
    .clk_i(clk), .reset_ni(rst1_n), .start_i(start1),
    .busy_o(busy1), .done_o(done1), .iter_o(iter1),
    .sel_muxa_o(muxa1), .sel_muxb_o(muxb1),
    .loada_o(la1), .loadb_o(lb1), .loadc_o(lc1)
  );

  // Word layout: {busy, done, iter[2:0], muxa, muxb[1:0], loada, loadb, loadc}
  function automatic logic [10:0] exp_word(input int st, input int i);
    logic [2:0] it;
    it = 3'(i);
    case (st)
      1:       return 11'b1_0_000_0_00_0_1_0;          // SEED_D
      2:       return 11'b1_0_000_0_00_1_0_1;          // SEED_N
      3:       return {2'b10, it, 6'b1_01_0_1_0};      // ITER_D
      4:       return {2'b10, it, 6'b1_01_1_0_1};      // ITER_N
      5:       return 11'b0_1_000_0_00_0_0_0;          // DONE
      default: return 11'b0;
    endcase
  endfunction

  // Scoreboard for the ITER=3 instance
  logic [10:0] sb_q[$];
  logic [10:0] prev_w = '0;
  logic [10:0] cw = '0;

  always @(negedge rst3_n) begin
    sb_q.delete();
    prev_w = '0;
  end

  always @(posedge clk) begin
    if (rst3_n && start3 && (prev_w == 11'b0 || prev_w[9])) begin
      sb_q.push_back(exp_word(1, 0));
      sb_q.push_back(exp_word(2, 0));
      for (int i = 0; i < 3; i++) begin
        sb_q.push_back(exp_word(3, i));
        sb_q.push_back(exp_word(4, i));
      end
      sb_q.push_back(exp_word(5, 0));
    end
  end

  // Behavioural datapath: seed ROM returns a coarse 1/d estimate
  real dval = 1.5, xval = 3.0, seed = 0.66;
  real ra = 0.0, rb = 0.0, rc = 0.0, opb;

  always @(negedge clk) begin
    logic [10:0] e;
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 11'b0;
    checks++;
    if (w3 !== e) begin
      errors++;
      $display("FAIL ctrl_word t=%0t got=%b want=%b", $time, w3, e);
    end
    if (e[9]) $display("division complete t=%0t A=%0.9f", $time, ra);
    prev_w = e;
    cw = w3;
  end

  always @(posedge clk) begin
    if (rst3_n) begin
      opb = (cw[4:3] == 2'b00) ? seed : rc;
      if (cw[1]) rb <= (cw[5] ? rb : dval) * opb;
      if (cw[2]) ra <= (cw[5] ? ra : xval) * opb;
      if (cw[0]) rc <= 2.0 - rb;
    end
  end

  // Reserved sel_muxb codes must never appear on either instance
  always @(negedge clk) begin
    checks += 2;
    assert (muxb3 !== 2'b10 && muxb3 !== 2'b11) else begin
      errors++;
      $display("FAIL muxb3_reserved t=%0t got=%b want=00/01", $time, muxb3);
    end
    assert (muxb1 !== 2'b10 && muxb1 !== 2'b11) else begin
      errors++;
      $display("FAIL muxb1_reserved t=%0t got=%b want=00/01", $time, muxb1);
    end
  end

  // Pulse start on u3; called at posedge+2. Returns edges to done, busy cycles, done count, A at done.
  task automatic run_one(output int lat, output int bcnt, output int ndone, output real a_done);
    start3 = 1'b1;
    @(posedge clk);
    #2 start3 = 1'b0;
    lat = -1; bcnt = 0; ndone = 0; a_done = 0.0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (busy3) bcnt++;
      if (done3) begin
        ndone++;
        if (lat < 0) begin
          lat = k;
          a_done = ra;
        end
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    #1;
    checks += 2;
    if (w3 !== 11'b0) begin errors++; $display("FAIL reset_u3 got=%b want=0", w3); end
    if (w1 !== 11'b0) begin errors++; $display("FAIL reset_u1 got=%b want=0", w1); end
    @(posedge clk);
    #2 rst3_n = 1'b1; rst1_n = 1'b1;
  endtask

  task automatic test_single();
    int lat, bcnt, nd;
    real a;
    run_one(lat, bcnt, nd, a);
    checks += 3;
    if (lat !== 8) begin errors++; $display("FAIL single_latency got=%0d want=8", lat); end
    if (bcnt !== 8) begin errors++; $display("FAIL single_busy got=%0d want=8", bcnt); end
    if (nd !== 1) begin errors++; $display("FAIL single_done_count got=%0d want=1", nd); end
  endtask

  task automatic test_datapath();
    int lat, bcnt, nd;
    real a, diff;
    run_one(lat, bcnt, nd, a);
    diff = (a > 2.0) ? a - 2.0 : 2.0 - a;
    checks++;
    if (!(lat == 8 && diff < (1.0 / 1048576.0))) begin
      errors++;
      $display("FAIL datapath_quotient got=%0.9f want=2.0 (lat=%0d)", a, lat);
    end
  endtask

  task automatic test_back_to_back();
    int dk[$];
    start3 = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 36; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (done3) dk.push_back(k);
      if (k == 24) start3 = 1'b0;
    end
    checks += 4;
    if (dk.size() !== 3) begin
      errors++;
      $display("FAIL b2b_done_count got=%0d want=3", dk.size());
    end else begin
      if (dk[0] !== 8) begin errors++; $display("FAIL b2b_done0 got=%0d want=8", dk[0]); end
      if (dk[1] !== 17) begin errors++; $display("FAIL b2b_done1 got=%0d want=17", dk[1]); end
      if (dk[2] !== 26) begin errors++; $display("FAIL b2b_done2 got=%0d want=26", dk[2]); end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic test_start_ignored();
    int lat, nd;
    lat = -1; nd = 0;
    start3 = 1'b1;
    @(posedge clk);
    #2 start3 = 1'b0;
    for (int k = 0; k < 22; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k == 4) start3 = 1'b1;
      if (k == 5) start3 = 1'b0;
      if (done3) begin
        nd++;
        if (lat < 0) lat = k;
      end
    end
    checks += 2;
    if (nd !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d want=1", nd); end
    if (lat !== 8) begin errors++; $display("FAIL ignore_latency got=%0d want=8", lat); end
    @(posedge clk);
    #2;
  endtask

  task automatic test_abort();
    int nd, lat, bcnt;
    real a;
    nd = 0;
    start3 = 1'b1;
    @(posedge clk);
    #2 start3 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
    end
    // now inside ITER_N, iteration 1
    checks += 2;
    if (w3 !== exp_word(4, 1)) begin
      errors++;
      $display("FAIL abort_pre_state got=%b want=%b", w3, exp_word(4, 1));
    end
    #2 rst3_n = 1'b0;
    #1;
    if (w3 !== 11'b0) begin errors++; $display("FAIL abort_async_clear got=%b want=0", w3); end
    @(posedge clk);
    #2 rst3_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (done3) nd++;
    end
    checks++;
    if (nd !== 0) begin errors++; $display("FAIL abort_no_done got=%0d want=0", nd); end
    #1;
    run_one(lat, bcnt, nd, a);
    checks += 2;
    if (lat !== 8) begin errors++; $display("FAIL abort_restart_latency got=%0d want=8", lat); end
    if (nd !== 1) begin errors++; $display("FAIL abort_restart_done got=%0d want=1", nd); end
  endtask

  task automatic test_iter1();
    int lat, bcnt, nd, itnz;
    lat = -1; bcnt = 0; nd = 0; itnz = 0;
    start1 = 1'b1;
    @(posedge clk);
    #2 start1 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (busy1) bcnt++;
      if (iter1 !== 3'd0) itnz++;
      if (done1) begin
        nd++;
        if (lat < 0) lat = k;
      end
    end
    $display("iter1 division complete latency=%0d", lat);
    checks += 4;
    if (lat !== 4) begin errors++; $display("FAIL iter1_latency got=%0d want=4", lat); end
    if (bcnt !== 4) begin errors++; $display("FAIL iter1_busy got=%0d want=4", bcnt); end
    if (nd !== 1) begin errors++; $display("FAIL iter1_done_count got=%0d want=1", nd); end
    if (itnz !== 0) begin errors++; $display("FAIL iter1_iter_nonzero got=%0d want=0", itnz); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_datapath();
    test_back_to_back();
    test_start_ignored();
    test_abort();
    test_iter1();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpdiv_ctrl.md
# fpdiv_ctrl

Control sequencer for the `fpdiv` Goldschmidt divider datapath. It generates the datapath control word (`sel_muxa`, `sel_muxb`, `loada`, `loadb`, `loadc`) that the divider bench currently drives by hand. A `start`/`done` handshake runs one complete division of the divider's two operands. It sits between the FPU issue logic and `fpdiv`, and drives the datapath control inputs directly.

## Interface
- `ITER`, default 3: number of Goldschmidt refinement iterations. Legal range is 1..7.
- `clk`, input, 1: rising-edge clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request one division. Sampled only in IDLE or DONE.
- `busy`, output, 1: high in SEED_D, SEED_N, ITER_D and ITER_N.
- `done`, output, 1: one-cycle pulse, high only in DONE. The quotient in datapath register A is valid while `done` is high.
- `iter`, output, 3: index of the current refinement iteration, 0..ITER-1. It is 0 outside the ITER states.
- `sel_muxa`, output, 1: multiplier operand A select.
  - 0: external operand (`d` or `x`).
  - 1: feedback from register A/B.
- `sel_muxb`, output, 2: multiplier operand B select.
  - 00: reciprocal seed ROM.
  - 01: register C (K = 2 − D).
  - 10 and 11: reserved, never driven.
- `loada`, output, 1: load register A (numerator N).
- `loadb`, output, 1: load register B (denominator D).
- `loadc`, output, 1: load register C (K = 2 − D, computed in the datapath).

## Operation
- The block is a Moore FSM. All outputs decode from registered state plus the iteration counter; none depend combinationally on `start`.
- The states and the outputs they drive (outputs not listed are 0):
  - IDLE: all outputs 0.
  - SEED_D: `sel_muxa`=0, `sel_muxb`=00, `loadb`=1. Computes D0 = d·seed.
  - SEED_N: `sel_muxa`=0, `sel_muxb`=00, `loada`=1, `loadc`=1. Computes N0 = x·seed and K0 = 2 − D0.
  - ITER_D: `sel_muxa`=1, `sel_muxb`=01, `loadb`=1. Computes D(i+1) = D(i)·K(i).
  - ITER_N: `sel_muxa`=1, `sel_muxb`=01, `loada`=1, `loadc`=1. Computes N(i+1) = N(i)·K(i) and K(i+1) = 2 − D(i+1). Register C is read before it is overwritten at the same edge.
  - DONE: `done`=1. All other outputs are 0.
- `busy` is 1 in SEED_D, SEED_N, ITER_D and ITER_N.
- Transitions:
  - IDLE → SEED_D when `start`=1.
  - SEED_D → SEED_N.
  - SEED_N → ITER_D, with the iteration counter cleared to 0.
  - ITER_D → ITER_N.
  - ITER_N → ITER_D with the counter incremented, while counter < ITER−1.
  - ITER_N → DONE when counter = ITER−1.
  - DONE → SEED_D if `start`=1 (back-to-back division), otherwise DONE → IDLE.
- `start` is ignored in every state except IDLE and DONE. There is no queuing and no error flag.
- The iteration counter is 3 bits wide. It resets to 0, clears on entry to ITER_D from SEED_N, and increments only on the ITER_N → ITER_D transition. It never wraps, because the ITER_N → DONE transition happens at ITER−1.
- `loada`, `loadb` and `loadc` are never all high together. `sel_muxb` never takes the values 10 or 11.

## Timing
- Reset: while `reset_n`=0, the state is IDLE, the counter is 0 and every output is 0, asynchronously. Asserting `reset_n` mid-division aborts the division with no partial `done`. The first `start` is accepted on the first rising edge after `reset_n` deasserts.
- Latency: call E0 the edge that samples `start`=1.
  - SEED_D holds from E0 to E1.
  - SEED_N holds from E1 to E2.
  - The ITER states occupy the next 2·ITER cycles.
  - `done` is high from edge E(2+2·ITER) to edge E(3+2·ITER).
  - For ITER=3, `done` is high between E8 and E9, and `busy` is high for 8 cycles.
- Throughput: if `start` is held high during DONE, the next SEED_D begins at E(3+2·ITER). That gives one division every 2·ITER+3 cycles.
- Load strobes are one cycle wide. The datapath captures on the same rising edge that ends the state.

## Test plan
- Reset with ITER=3: pulse `reset_n` low mid-cycle → all outputs 0 immediately. Then pulse `start` at E0 → `busy` 1 for E0..E8, the control word sequence is SEED_D, SEED_N, (ITER_D, ITER_N)×3, `iter` reads 0,0,1,1,2,2 across the ITER states, and `done`=1 for exactly the cycle E8..E9.
- Datapath co-simulation with `fpdiv`, d=1.5 and x=3.0 → register A = 2.0 within 2^-20 while `done`=1.
- Hold `start` high continuously → `done` pulses every 9 cycles, there are no IDLE cycles between divisions, and the SEED_D control word immediately follows DONE.
- Pulse `start` during ITER_D (iteration 1) → sequence unaffected, and only one `done` is produced.
- Assert `reset_n`=0 during ITER_N (iteration 1) → outputs 0 asynchronously and no `done`. After release, a fresh `start` completes normally in 8 edges.
- ITER=1 → `done` at E4. Check on every cycle, with an assertion, that `sel_muxb`≠10 and ≠11.
